// File: rtl/stream_pkg.sv
// Shared types and init-value helpers for the stream reduction block.
package stream_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRun    = 2'd1,
    StResult = 2'd2
  } state_e;

  // Widest data word the init helpers cover.
  localparam int unsigned MaxWidth = 64;

  // Largest signed value of a w-bit word, zero-extended to MaxWidth.
  function automatic logic [MaxWidth-1:0] smax_init(int unsigned w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Smallest signed value of a w-bit word, zero-extended to MaxWidth.
  function automatic logic [MaxWidth-1:0] smin_init(int unsigned w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/stream_reduce_acc.sv
// Sum / count / min / max accumulator with synchronous clear and beat enable.
module stream_reduce_acc
  import stream_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        clear_i,
  input  logic                        enable_i,
  input  logic signed [WIDTH-1:0]     data_i,
  output logic signed [WIDTH-1:0]     sum_o,
  output logic        [CNT_WIDTH-1:0] count_o,
  output logic signed [WIDTH-1:0]     min_o,
  output logic signed [WIDTH-1:0]     max_o
);

  localparam logic [MaxWidth-1:0]  MinFull = smax_init(WIDTH);
  localparam logic [MaxWidth-1:0]  MaxFull = smin_init(WIDTH);
  // min starts at the largest value and max at the smallest, so the first beat wins both.
  localparam logic [WIDTH-1:0]     MinInit = MinFull[WIDTH-1:0];
  localparam logic [WIDTH-1:0]     MaxInit = MaxFull[WIDTH-1:0];
  localparam logic [CNT_WIDTH-1:0] CntOne  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic signed [WIDTH-1:0]     sum_q, min_q, max_q;
  logic        [CNT_WIDTH-1:0] count_q;

  // Accumulator registers: reset to zero, clear to init values, fold in enabled beats.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sum_q   <= '0;
      count_q <= '0;
      min_q   <= '0;
      max_q   <= '0;
    end else if (clear_i) begin
      sum_q   <= '0;
      count_q <= '0;
      min_q   <= MinInit;
      max_q   <= MaxInit;
    end else if (enable_i) begin
      sum_q <= sum_q + data_i;
      if (count_q != '1) begin
        count_q <= count_q + CntOne;
      end
      if (data_i < min_q) begin
        min_q <= data_i;
      end
      if (data_i > max_q) begin
        max_q <= data_i;
      end
    end
  end

  assign sum_o   = sum_q;
  assign count_o = count_q;
  assign min_o   = min_q;
  assign max_o   = max_q;

endmodule

// File: rtl/stream_reduce.sv
// Stream reduction: consumes beats from an upstream generator until done, then
// presents sum, count, min and max with a valid/ready handshake.
module stream_reduce
  import stream_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                        _clock,
  input  logic                        _reset,
  input  logic                        _start,
  input  logic                        in_valid,
  input  logic signed [WIDTH-1:0]     in_data,
  input  logic                        in_done,
  output logic                        in_ready,
  input  logic                        _ready,
  output logic                        _valid,
  output logic                        _done,
  output logic signed [WIDTH-1:0]     _out0,
  output logic        [CNT_WIDTH-1:0] _out1,
  output logic signed [WIDTH-1:0]     _out2,
  output logic signed [WIDTH-1:0]     _out3
);

  state_e state_q, state_d;
  logic   acc_clear, acc_en;

  // State register with synchronous active-low reset.
  always_ff @(posedge _clock) begin
    if (!_reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake outputs; start is honoured only from idle.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    _valid    = 1'b0;
    _done     = 1'b0;
    acc_clear = 1'b0;
    acc_en    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (_start) begin
          state_d   = StRun;
          acc_clear = 1'b1;
        end
      end
      StRun: begin
        in_ready = 1'b1;
        // A beat arriving with done is still folded in.
        acc_en   = in_valid;
        if (in_done) begin
          state_d = StResult;
        end
      end
      StResult: begin
        _valid = 1'b1;
        _done  = 1'b1;
        if (_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  stream_reduce_acc #(
    .WIDTH     (WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_acc (
    .clk_i    (_clock),
    .rst_ni   (_reset),
    .clear_i  (acc_clear),
    .enable_i (acc_en),
    .data_i   (in_data),
    .sum_o    (_out0),
    .count_o  (_out1),
    .min_o    (_out2),
    .max_o    (_out3)
  );

endmodule

// File: doc/stream_reduce.md
STREAM_REDUCE -- requirements
Module: stream_reduce

Interface
REQ-001 SHALL have parameter WIDTH, default 32, which sets the width of the data and result words.
REQ-002 SHALL have parameter CNT_WIDTH, default 32, which sets the width of the beat counter.
REQ-003 SHALL have port _clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port _reset, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port _start, input, 1 bit: one-cycle pulse that begins a reduction.
REQ-006 SHALL have port in_valid, input, 1 bit: the upstream generator's _valid.
REQ-007 SHALL have port in_data, input, signed WIDTH bits: the upstream generator's _out0.
REQ-008 SHALL have port in_done, input, 1 bit: the upstream generator's _done.
REQ-009 SHALL have port in_ready, output, 1 bit: driven into the upstream generator's _ready.
REQ-010 SHALL have port _ready, input, 1 bit: downstream is ready to take the result.
REQ-011 SHALL have port _valid, output, 1 bit: the result is valid.
REQ-012 SHALL have port _done, output, 1 bit: the reduction is complete.
REQ-013 SHALL have port _out0, output, signed WIDTH bits: sum of accepted beats.
REQ-014 SHALL have port _out1, output, CNT_WIDTH bits: count of accepted beats.
REQ-015 SHALL have port _out2, output, signed WIDTH bits: minimum accepted value.
REQ-016 SHALL have port _out3, output, signed WIDTH bits: maximum accepted value.

Function
REQ-017 SHALL implement FSM states IDLE, RUN and RESULT.
REQ-018 IDLE SHALL drive in_ready=0, _valid=0, _done=0, and move to RUN on _start=1.
REQ-019 Entering RUN SHALL load sum=0, count=0, min=signed max (0x7FFFFFFF at WIDTH=32) and max=signed min (0x80000000).
REQ-020 RUN SHALL drive in_ready=1 in every cycle and accept a beat when in_valid && in_ready.
REQ-021 For each accepted beat, the block SHALL set sum+=in_data (wraps mod 2^WIDTH), count+=1 (saturates at all-ones), min=smaller signed value, max=larger signed value.
REQ-022 In RUN, in_done=1 SHALL move the FSM to RESULT on the next edge; if in_valid=1 in that same cycle, the beat SHALL be included first.
REQ-023 _start during RUN or RESULT SHALL be ignored.
REQ-024 RESULT SHALL drive in_ready=0, _valid=1 and _done=1, and hold _out0.._out3 stable until _ready=1.
REQ-025 RESULT with _ready=1 SHALL return to IDLE on the next edge; result latency is 1 cycle from the in_done edge.
REQ-026 _start arriving in the same cycle the FSM returns from RESULT to IDLE SHALL be ignored; _start SHALL be accepted in IDLE only.
REQ-027 An empty stream (in_done with no accepted beats) SHALL give a result of sum 0, count 0, min 0x7FFFFFFF, max 0x80000000.
REQ-028 _out0.._out3 SHALL keep their last result in IDLE and change only in RUN.
REQ-029 in_valid without in_ready (IDLE or RESULT) SHALL NOT change any state.

Reset
REQ-030 _reset=0 at a rising edge SHALL force state=IDLE, in_ready=0, _valid=0, _done=0, _out0=0, _out1=0, _out2=0 and _out3=0.
REQ-031 Reset in RUN or RESULT SHALL abandon the reduction and drop the pending result, with no partial result emitted.

Structure
REQ-032 Package stream_pkg SHALL hold the state enum (IDLE/RUN/RESULT) and the WIDTH-derived signed min/max init constants.
REQ-033 The datapath SHALL be one sub-module, stream_reduce_acc (sum/count/min/max with clear and enable), with the FSM in stream_reduce.

Verification
REQ-034 The bench SHALL drive upstream beats 0,2,4,6,8 then done, with _ready=1, and check out0=20, out1=5, out2=0, out3=8, with _valid=_done=1 for exactly 1 cycle.
REQ-035 The bench SHALL drive beats 1,4,7,10 with in_valid=1 on the in_done cycle for the last beat, and check 22, 4, 1, 10.
REQ-036 The bench SHALL drive an empty stream (done on the first RUN cycle) and check 0, 0, 0x7FFFFFFF, 0x80000000.
REQ-037 The bench SHALL drive beats -5,3,0x7FFFFFFF and check sum wrap 0x7FFFFFFD, min -5, max 0x7FFFFFFF.
REQ-038 The bench SHALL hold _ready=0 for 4 cycles in RESULT and check that the outputs stay stable, a _start in that window is ignored, and IDLE follows one cycle after _ready=1.
REQ-039 The bench SHALL pulse _reset=0 mid-RUN after 2 beats and check that all outputs are 0 and state is IDLE, and that a new _start yields a clean result.
